// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM states, parameter
// defaults and the address legality check.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEPTH_DEFAULT   = 256;
  localparam int LATENCY_DEFAULT = 2;
  localparam int CNT_W           = 4;
  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

  // Misaligned or beyond the last word; 64-bit compare avoids wrap of depth*4.
  function automatic logic addr_error(input logic [31:0] addr, input int depth);
    logic [63:0] limit;
    limit = 64'(depth) << 2;
    return ((addr & ALIGN_MASK) != 32'd0) || ({32'd0, addr} >= limit);
  endfunction

endpackage

// File: rtl/dm_array.sv
// Word storage for the responder: synchronous write, registered read,
// whole array cleared asynchronously by rst_n.
module dm_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             clr,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_r [DEPTH];
  logic [31:0] rdata_r;

  // Storage write port and read register; clr zeroes the read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
      rdata_r <= 32'd0;
    end else begin
      if (wr_en) begin
        mem_r[idx] <= wdata;
      end
      if (rd_en) begin
        rdata_r <= mem_r[idx];
      end else if (clr) begin
        rdata_r <= 32'd0;
      end
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dm_responder.sv
// Fixed-latency CPU data-memory responder: accepts one request at a time,
// answers LATENCY cycles later and holds the response until taken.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int LATENCY = LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r, cnt_next_s;
  logic               write_r;
  logic [31:0]        addr_r;
  logic [31:0]        wdata_r;
  logic               ready_r;
  logic               valid_r;
  logic               err_r, err_next_s;
  logic               accept_s;
  logic               wr_en_s;
  logic               rd_en_s;
  logic               clr_s;
  logic               addr_err_s;
  logic [31:0]        rdata_s;

  assign addr_err_s = addr_error(addr_r, DEPTH);

  // Next-state, counter and storage-strobe decode.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    err_next_s   = err_r;
    accept_s     = 1'b0;
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    clr_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s     = 1'b1;
          state_next_s = ST_WAIT;
          cnt_next_s   = CNT_W'(LATENCY - 1);
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_next_s = ST_RESP;
          err_next_s   = addr_err_s;
          if (addr_err_s) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
          end else begin
            wr_en_s = write_r;
            rd_en_s = ~write_r;
          end
        end else begin
          cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next_s = ST_IDLE;
          err_next_s   = 1'b0;
          clr_s        = 1'b1;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        err_next_s   = 1'b0;
        clr_s        = 1'b1;
      end
    endcase
  end

  // State, counter, request capture and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      write_r <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= (state_next_s == ST_IDLE);
      valid_r <= (state_next_s == ST_RESP);
      err_r   <= err_next_s;
      if (accept_s) begin
        write_r <= req_write;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
    end
  end

  dm_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en_s),
    .rd_en (rd_en_s),
    .clr   (clr_s),
    .idx   (addr_r[IDX_W+1:2]),
    .wdata (wdata_r),
    .rdata (rdata_s)
  );

  assign req_ready  = ready_r;
  assign resp_valid = valid_r;
  assign resp_err   = err_r;
  assign resp_rdata = rdata_s;

endmodule

// File: tb/tb_dm_responder.sv
// Randomized scoreboard bench for dm_responder: a LATENCY=2 instance driven by
// request/response tasks, plus a LATENCY=1 instance under continuous req_valid.
module tb_dm_responder;

  localparam int DEPTH = 256;
  localparam int LAT0  = 2;
  localparam int LAT1  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1 = 1'b0, req_write1 = 1'b0, resp_ready1 = 1'b1;
  logic [31:0] req_addr1 = 32'd0, req_wdata1 = 32'd0;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: an acceptance yields its response from plain address rules.
  logic        prev_valid = 1'b0;
  logic [31:0] held_rdata = 32'd0;
  logic        held_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      foreach (ref_mem[i]) ref_mem[i] = 32'd0;
      prev_valid = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
    end else begin
      if (req_valid && req_ready) begin
        exp_t e;
        logic bad;
        bad = (req_addr % 4 != 0) || (req_addr >= DEPTH * 4);
        e.err   = bad;
        e.rdata = (bad || req_write) ? 32'd0 : ref_mem[req_addr / 4];
        e.acc   = cyc + 1;
        if (req_write && !bad) ref_mem[req_addr / 4] = req_wdata;
        sb.push_back(e);
      end
      if (resp_valid && !prev_valid) begin
        chk("resp_has_request", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_latency", 32'(cyc - e.acc), 32'(LAT0));
        end
        held_rdata = resp_rdata;
        held_err   = resp_err;
      end else if (resp_valid) begin
        chk("hold_rdata", resp_rdata, held_rdata);
        chk("hold_err", 32'(resp_err), 32'(held_err));
      end
      if (resp_valid) begin
        chk("ready_low_in_resp", 32'(req_ready), 32'd0);
      end else begin
        chk("idle_rdata_zero", resp_rdata, 32'd0);
        chk("idle_err_zero", 32'(resp_err), 32'd0);
      end
      if (!resp_valid && prev_valid) chk("ready_after_handshake", 32'(req_ready), 32'd1);
      prev_valid = resp_valid;
    end
  end

  // Back-to-back instance: acceptance spacing and no ready alongside a response.
  int last_acc1 = -1;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_acc1 = -1;
    end else begin
      if (req_valid1 && req_ready1) begin
        if (last_acc1 >= 0) chk("accept_spacing_lat1", 32'(cyc - last_acc1), 32'd3);
        last_acc1 = cyc;
      end
      if (resp_valid1) chk("no_accept_while_resp", 32'(req_ready1), 32'd0);
    end
  end

  always @(posedge clk) begin
    #1;
    req_write1 = 1'($urandom);
    req_addr1  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    req_wdata1 = $urandom;
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
    int t;
    t = 0;
    while (!req_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid  = 1'($urandom);
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    resp_ready = 1'($urandom);
    t = 0;
    while (!resp_valid && t < 40) begin
      @(posedge clk); #1;
      resp_ready = 1'($urandom);
      req_addr   = $urandom;
      t++;
    end
    resp_ready = 1'b0;
    if (t >= 40) begin
      chk("resp_timeout", 32'(resp_valid), 32'd1);
      req_valid = 1'b0;
      return;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      req_wdata = $urandom;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
    if (r <= 7) return {28'd0, 2'($urandom_range(0, 3)), 2'b00};
    if (r == 8) return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    return 32'h0000_0400 + ($urandom & 32'h7FFF_FFFF);
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid1 = 1'b1;

    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 1);
    do_req(1'b0, 32'h0000_0003, 32'h0, 0);
    do_req(1'b0, 32'h0000_0400, 32'h0, 0);
    do_req(1'b0, 32'h0000_0010, 32'h0, 5);

    do_req(1'b1, 32'h0000_0020, 32'h0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0020, 32'h0, 0);

    do_req(1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 0);
    do_req(1'b0, 32'h0000_03FC, 32'h0, 2);
    do_req(1'b0, 32'h0000_03F8, 32'h0, 0);

    for (int k = 0; k < 200; k++) begin
      do_req(1'($urandom), rand_addr(), $urandom, int'($urandom_range(0, 3)));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 The block SHALL have parameters: DEPTH, default 256, storage size in 32-bit words; LATENCY, default 2, cycles from request acceptance to response, legal range 1..15.
REQ-002 The block SHALL have the ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  CPU data-memory request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- resp_valid  output  1  response present
- resp_ready  input  1  CPU accepts the response
- resp_rdata  output  32  load data; 0 for stores and errors
- resp_err  output  1  request was misaligned or out of range

Function
REQ-003 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-004 In IDLE the block SHALL drive req_ready=1; it SHALL drive req_ready=0 in WAIT and RESP.
REQ-005 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1. At that edge the block SHALL capture req_write, req_addr and req_wdata, load the latency counter with LATENCY-1, and enter WAIT.
REQ-006 In WAIT the counter SHALL decrement each cycle. When the counter is 0, the next edge SHALL enter RESP. resp_valid SHALL therefore first be high exactly LATENCY cycles after the acceptance edge.
REQ-007 A request SHALL be in error when addr[1:0]!=0 or addr>=DEPTH*4. Word index = addr[log2(DEPTH)+1:2].
REQ-008 On the edge entering RESP:
- valid store: write wdata to the indexed word
- valid load: register the indexed word into resp_rdata
- error: no storage access; resp_err=1; resp_rdata=0
REQ-009 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1. That edge SHALL return the FSM to IDLE and clear resp_valid, resp_err and resp_rdata.
REQ-010 A new request SHALL NOT be accepted in the cycle the response handshake completes. The minimum request-to-request spacing SHALL be LATENCY+2 cycles.
REQ-011 req_valid outside IDLE SHALL be ignored. No input SHALL change captured state once a request is accepted.
REQ-012 resp_ready while resp_valid=0 SHALL have no effect.
REQ-013 A load to a word stored by the immediately preceding request SHALL return the new data (no read-after-write hazard).

Reset
REQ-014 While rst_n=0, the block SHALL hold FSM=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, counter=0, and all storage words=0.
REQ-015 Reset asserted in WAIT or RESP SHALL abort the operation immediately. A pending store SHALL be discarded and leave no storage change.
REQ-016 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Structure
REQ-017 The shared package dm_pkg SHALL hold the FSM state enum, the DEPTH and LATENCY defaults, and the address-alignment mask constant.
REQ-018 Storage SHALL be a sub-module, dm_array: synchronous write, registered read, asynchronous clear on rst_n. The FSM and counter SHALL reside in dm_responder.

Verification
REQ-019 Store addr=0x0000_0010, wdata=0xDEAD_BEEF, then load 0x10 -> resp_rdata=0xDEAD_BEEF, resp_err=0, resp_valid rising 2 cycles after each acceptance.
REQ-020 Load from 0x0000_0003 -> resp_err=1, resp_rdata=0. Load from 0x0000_0400 (DEPTH=256) -> resp_err=1. Storage is unchanged in both cases.
REQ-021 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and req_ready=0 are stable throughout. Raise resp_ready -> IDLE next edge, req_ready=1.
REQ-022 Store 0x1234_5678 to 0x20, assert rst_n=0 during WAIT, release, then load 0x20 -> resp_rdata=0.
REQ-023 Hold req_valid=1 continuously with LATENCY=1 -> acceptances are exactly 3 cycles apart, and no request is accepted while resp_valid=1.
REQ-024 Store to the last word 0x3FC, then load it -> data returned. Load from unwritten word 0x3F8 -> 0.
